var_delay_line: RTL and testbench

Parametrised delay line with a run-time selectable depth, a clock enable and a flush. Each sample carries a valid bit that travels through the pipe with it. It realigns pixel data and sync/blank signals against the variable-latency stages in the video pipeline, for example when a sprite or overlay path changes its latency. It replaces the fixed-depth, single-width delay stages where the latency is not known at build time.

---
 rtl/var_delay_line_pkg.sv | 19 +
 rtl/var_delay_line_delay_tap_mux.sv | 21 ++
 rtl/var_delay_line.sv | 60 ++++++
 tb/tb_var_delay_line.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/var_delay_line_pkg.sv
// Shared constants and helpers for the variable-depth delay line and its tap mux.
package var_delay_line_pkg;

   // Deepest sprite/overlay path latency in the video pipeline.
   localparam int DEF_MAX_DEL = 16;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

   // Tap select must encode 0..max_del inclusive.
   function automatic int sel_w(input int max_del);
      return (clog2(max_del + 1) < 1) ? 1 : clog2(max_del + 1);
   endfunction

endpackage

// File: rtl/var_delay_line_delay_tap_mux.sv
// (NUM_IN)-input tap mux; selects above the last input clamp to the last input.
module delay_tap_mux
   import var_delay_line_pkg::*;
#(
   parameter int DW     = 9,
   parameter int NUM_IN = 17,
   parameter int SEL_W  = 5
) (
   input  logic [NUM_IN-1:0][DW-1:0] i_taps,
   input  logic [SEL_W-1:0]          i_sel,
   output logic [DW-1:0]             o_tap
);

   always_comb begin
      o_tap = i_taps[NUM_IN-1];
      for (int i = 0; i < NUM_IN; i++) begin
         if (i_sel == SEL_W'(i)) o_tap = i_taps[i];
      end
   end

endmodule

// File: rtl/var_delay_line.sv
// Delay line with run-time depth 0..MAX_DEL, clock enable and flush; valid travels per stage.
module var_delay_line
   import var_delay_line_pkg::*;
#(
   parameter int                WIDTH     = 8,
   parameter int                MAX_DEL   = DEF_MAX_DEL,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0,
   localparam int               SEL_W     = sel_w(MAX_DEL)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             flush,
   input  logic [SEL_W-1:0] del_sel,
   input  logic [WIDTH-1:0] din,
   input  logic             din_vld,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld
);

   // Tap 0 is the live input (bypass); tap k is the output of stage k-1.
   logic [MAX_DEL:0][WIDTH:0] w_taps;
   logic [WIDTH:0]            w_sel_tap;

   assign w_taps[0] = {din, din_vld};

   for (genvar k = 0; k < MAX_DEL; k++) begin : g_stage
      logic [WIDTH-1:0] r_data;
      logic             r_vld;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_data <= RESET_VAL;
            r_vld  <= 1'b0;
         end else if (flush) begin
            r_data <= RESET_VAL;
            r_vld  <= 1'b0;
         end else if (en) begin
            r_data <= w_taps[k][WIDTH:1];
            r_vld  <= w_taps[k][0];
         end
      end

      assign w_taps[k+1] = {r_data, r_vld};
   end

   delay_tap_mux #(
      .DW     (WIDTH + 1),
      .NUM_IN (MAX_DEL + 1),
      .SEL_W  (SEL_W)
   ) u_tap_mux (
      .i_taps (w_taps),
      .i_sel  (del_sel),
      .o_tap  (w_sel_tap)
   );

   assign dout     = w_sel_tap[WIDTH:1];
   assign dout_vld = w_sel_tap[0];

endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line: fill, enable gating, tap change, flush, bypass/clamp, async reset.
module tb_var_delay_line;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       flush;
   logic [4:0] del_sel;
   logic [7:0] din;
   logic       din_vld;
   logic [7:0] dout;
   logic       dout_vld;

   int checks   = 0;
   int failures = 0;

   var_delay_line #(
      .WIDTH     (8),
      .MAX_DEL   (16),
      .RESET_VAL (8'h00)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .flush    (flush),
      .del_sel  (del_sel),
      .din      (din),
      .din_vld  (din_vld),
      .dout     (dout),
      .dout_vld (dout_vld)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   // N=4 fill from an empty pipe: din=e on edge e, output valid from edge 4.
   task automatic test_fill(input string tag);
      logic [8:0] exp;
      del_sel = 5'd4;
      en      = 1'b1;
      din_vld = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         din = 8'(e);
         tick();
         exp = (e < 4) ? 9'h000 : {8'(e - 3), 1'b1};
         checks++;
         if ({dout, dout_vld} !== exp) begin
            failures++;
            $display("FAIL %s edge%0d: got %h/%b want %h/%b", tag, e, dout, dout_vld, exp[8:1], exp[0]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; flush = 1'b0;
      del_sel = 5'd4; din = 8'h55; din_vld = 1'b1;
      #1;
      checks++;
      if ({dout, dout_vld} !== 9'h000) begin
         failures++;
         $display("FAIL reset_n4: got %h/%b want 00/0", dout, dout_vld);
      end
      del_sel = 5'd0;
      #1;
      checks++;
      if ({dout, dout_vld} !== {8'h55, 1'b1}) begin
         failures++;
         $display("FAIL reset_bypass: got %h/%b want 55/1", dout, dout_vld);
      end
      tick();
      rst_n = 1'b1;
      test_fill("fill");
   endtask

   task automatic test_enable();
      logic [7:0] feed [5];
      logic [7:0] want [5];
      do_flush();
      del_sel = 5'd3;
      checks++;
      if ({dout, dout_vld} !== 9'h000) begin
         failures++;
         $display("FAIL en_flushed: got %h/%b want 00/0", dout, dout_vld);
      end
      en = 1'b1; din_vld = 1'b1;
      din = 8'hA1; tick();
      din = 8'hA2; tick();
      en = 1'b0; din = 8'hEE;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({dout, dout_vld} !== 9'h000) begin
            failures++;
            $display("FAIL en_hold_empty c%0d: got %h/%b want 00/0", c, dout, dout_vld);
         end
      end
      en = 1'b1; din = 8'hA3; tick();
      checks++;
      if ({dout, dout_vld} !== {8'hA1, 1'b1}) begin
         failures++;
         $display("FAIL en_third_edge: got %h/%b want a1/1", dout, dout_vld);
      end
      en = 1'b0; din = 8'hEE;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({dout, dout_vld} !== {8'hA1, 1'b1}) begin
            failures++;
            $display("FAIL en_hold_a1 c%0d: got %h/%b want a1/1", c, dout, dout_vld);
         end
      end
      en = 1'b1;
      feed = '{8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
      want = '{8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
      for (int i = 0; i < 5; i++) begin
         din = feed[i]; tick();
         checks++;
         if ({dout, dout_vld} !== {want[i], 1'b1}) begin
            failures++;
            $display("FAIL en_resume%0d: got %h/%b want %h/1", i, dout, dout_vld, want[i]);
         end
      end
   endtask

   task automatic test_tap_change();
      logic [8:0] exp;
      do_flush();
      del_sel = 5'd2; en = 1'b1; din_vld = 1'b1;
      for (int s = 1; s <= 3; s++) begin
         din = 8'h10 + 8'(s); tick();
      end
      checks++;
      if ({dout, dout_vld} !== {8'h12, 1'b1}) begin
         failures++;
         $display("FAIL tap_n2: got %h/%b want 12/1", dout, dout_vld);
      end
      del_sel = 5'd6; #1;
      checks++;
      if ({dout, dout_vld} !== 9'h000) begin
         failures++;
         $display("FAIL tap_to6: got %h/%b want 00/0", dout, dout_vld);
      end
      for (int s = 4; s <= 7; s++) begin
         din = 8'h10 + 8'(s); tick();
         exp = (s < 6) ? 9'h000 : {8'h10 + 8'(s - 5), 1'b1};
         checks++;
         if ({dout, dout_vld} !== exp) begin
            failures++;
            $display("FAIL tap_n6 s%0d: got %h/%b want %h/%b", s, dout, dout_vld, exp[8:1], exp[0]);
         end
      end
      del_sel = 5'd2; #1;
      checks++;
      if ({dout, dout_vld} !== {8'h16, 1'b1}) begin
         failures++;
         $display("FAIL tap_back2: got %h/%b want 16/1", dout, dout_vld);
      end
      din = 8'h18; tick();
      checks++;
      if ({dout, dout_vld} !== {8'h17, 1'b1}) begin
         failures++;
         $display("FAIL tap_after2: got %h/%b want 17/1", dout, dout_vld);
      end
   endtask

   task automatic test_flush();
      logic [8:0] exp;
      do_flush();
      del_sel = 5'd5; en = 1'b1; din_vld = 1'b1;
      for (int s = 1; s <= 6; s++) begin
         din = 8'h30 + 8'(s); tick();
      end
      checks++;
      if ({dout, dout_vld} !== {8'h32, 1'b1}) begin
         failures++;
         $display("FAIL flush_full: got %h/%b want 32/1", dout, dout_vld);
      end
      flush = 1'b1; en = 1'b0; din = 8'h99; din_vld = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if ({dout, dout_vld} !== 9'h000) begin
         failures++;
         $display("FAIL flush_out: got %h/%b want 00/0", dout, dout_vld);
      end
      del_sel = 5'd1; #1;
      checks++;
      if ({dout, dout_vld} !== 9'h000) begin
         failures++;
         $display("FAIL flush_stage0: got %h/%b want 00/0", dout, dout_vld);
      end
      del_sel = 5'd5; en = 1'b1;
      for (int s = 0; s < 6; s++) begin
         din = 8'h40 + 8'(s); tick();
         exp = (s < 4) ? 9'h000 : {8'h40 + 8'(s - 4), 1'b1};
         checks++;
         if ({dout, dout_vld} !== exp) begin
            failures++;
            $display("FAIL flush_refill s%0d: got %h/%b want %h/%b", s, dout, dout_vld, exp[8:1], exp[0]);
         end
      end
   endtask

   task automatic test_bypass_clamp();
      logic [8:0] exp;
      del_sel = 5'd0; din = 8'h5A; din_vld = 1'b1; #1;
      checks++;
      if ({dout, dout_vld} !== {8'h5A, 1'b1}) begin
         failures++;
         $display("FAIL bypass_a: got %h/%b want 5a/1", dout, dout_vld);
      end
      din = 8'hC3; din_vld = 1'b0; #1;
      checks++;
      if ({dout, dout_vld} !== {8'hC3, 1'b0}) begin
         failures++;
         $display("FAIL bypass_b: got %h/%b want c3/0", dout, dout_vld);
      end
      do_flush();
      del_sel = 5'd31; en = 1'b1; din_vld = 1'b1;
      for (int s = 1; s <= 17; s++) begin
         din = 8'h60 + 8'(s); tick();
         exp = (s < 16) ? 9'h000 : {8'h60 + 8'(s - 15), 1'b1};
         if (s >= 14) begin
            checks++;
            if ({dout, dout_vld} !== exp) begin
               failures++;
               $display("FAIL clamp31 s%0d: got %h/%b want %h/%b", s, dout, dout_vld, exp[8:1], exp[0]);
            end
         end
      end
      del_sel = 5'd16; #1;
      checks++;
      if ({dout, dout_vld} !== {8'h62, 1'b1}) begin
         failures++;
         $display("FAIL clamp16: got %h/%b want 62/1", dout, dout_vld);
      end
   endtask

   task automatic test_async_reset();
      del_sel = 5'd4; #1;
      checks++;
      if ({dout, dout_vld} !== {8'h6E, 1'b1}) begin
         failures++;
         $display("FAIL arst_pre: got %h/%b want 6e/1", dout, dout_vld);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({dout, dout_vld} !== 9'h000) begin
         failures++;
         $display("FAIL arst_now: got %h/%b want 00/0", dout, dout_vld);
      end
      del_sel = 5'd16; #1;
      checks++;
      if ({dout, dout_vld} !== 9'h000) begin
         failures++;
         $display("FAIL arst_n16: got %h/%b want 00/0", dout, dout_vld);
      end
      tick();
      rst_n = 1'b1;
      test_fill("refill");
   endtask

   initial begin
      test_reset();
      test_enable();
      test_tap_change();
      test_flush();
      test_bypass_clamp();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
